// File: rtl/jtag_frame_loader_if.sv
// Configuration stream in, fabric frame writes out.
// slave: loader side; master: TAP/fabric side.
interface jtag_frame_loader_if #(
    parameter int FRAME_BITS = 32,
    parameter int MAX_FRAMES = 20
);
    logic                  config_strobe;
    logic [31:0]           config_data;
    logic [FRAME_BITS-1:0] frame_data;
    logic [MAX_FRAMES-1:0] frame_strobe;
    logic                  busy;
    logic                  config_done;
    logic                  error;

    modport master (
        output config_strobe, config_data,
        input  frame_data, frame_strobe,
        input  busy, config_done, error
    );

    modport slave (
        input  config_strobe, config_data,
        output frame_data, frame_strobe,
        output busy, config_done, error
    );
endinterface

// File: rtl/jtag_frame_loader.sv
// Turns the TAP config word stream into one-hot fabric frame writes.
// Ports: clk, reset (sync, active-high), bus (slave modport).
module jtag_frame_loader #(
    parameter int          FRAME_WORDS   = 1,
    parameter int          MAX_FRAMES    = 20,
    parameter int          FRAME_INDEX_W = 5,
    parameter logic [31:0] SYNC_WORD     = 32'hFAB0_FAB1,
    parameter int          FRAME_BITS    = 32 * FRAME_WORDS
) (
    input logic clk,
    input logic reset,
    jtag_frame_loader_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] HEADER = 2'd1;
    localparam logic [1:0] DATA   = 2'd2;
    localparam int CNT_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

    logic r_s1, r_s2, r_s3;
    logic [1:0] r_state;
    logic [FRAME_INDEX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [FRAME_BITS-1:0] r_frame_data;
    logic [MAX_FRAMES-1:0] r_frame_strobe;
    logic r_busy, r_done, r_error;

    logic w_word_valid;
    logic [31:0] w_word;
    logic [1:0] w_op;
    logic [FRAME_INDEX_W-1:0] w_hdr_idx;
    logic w_idx_ok;
    logic w_is_sync;
    logic w_last;
    logic [1:0] w_next_state;
    logic [FRAME_BITS-1:0] w_assembled;

    // Rising edge of the synchronised strobe; a held level gives one word.
    assign w_word_valid = r_s2 & ~r_s3;
    assign w_word = bus.config_data;
    assign w_op = w_word[31:30];
    assign w_hdr_idx = w_word[FRAME_INDEX_W-1:0];
    assign w_idx_ok = {{(32-FRAME_INDEX_W){1'b0}}, w_hdr_idx} < MAX_FRAMES;
    assign w_is_sync = (w_word == SYNC_WORD);
    assign w_last = (r_cnt == CNT_W'(FRAME_WORDS - 1));

    generate
        if (FRAME_WORDS == 1) begin : g_single
            assign w_assembled = w_word;
        end else begin : g_multi
            // Holds the earlier words of the frame; oldest ends up in the MSBs.
            logic [FRAME_BITS-33:0] r_shift;
            assign w_assembled = {r_shift, w_word};
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_shift <= '0;
                end else if (w_word_valid && r_state == DATA) begin
                    r_shift <= w_assembled[FRAME_BITS-33:0];
                end
            end
        end
    endgenerate

    always_comb begin
        w_next_state = r_state;
        if (w_word_valid) begin
            unique case (r_state)
                IDLE:    if (w_is_sync) w_next_state = HEADER;
                HEADER:  w_next_state = (w_op == 2'b00 && w_idx_ok) ? DATA : IDLE;
                DATA:    if (w_last) w_next_state = HEADER;
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
            r_state <= IDLE;
            r_idx <= '0;
            r_cnt <= '0;
            r_frame_data <= '0;
            r_frame_strobe <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_s1 <= bus.config_strobe;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            r_state <= w_next_state;
            r_busy <= (w_next_state != IDLE);
            r_frame_strobe <= '0;
            r_done <= 1'b0;
            if (w_word_valid) begin
                unique case (r_state)
                    IDLE: begin
                        if (w_is_sync) r_error <= 1'b0;
                    end
                    HEADER: begin
                        unique case (w_op)
                            2'b00: begin
                                if (w_idx_ok) begin
                                    r_idx <= w_hdr_idx;
                                    r_cnt <= '0;
                                end else begin
                                    r_error <= 1'b1;
                                end
                            end
                            2'b01:   r_done <= 1'b1;
                            default: r_error <= 1'b1;
                        endcase
                    end
                    DATA: begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_frame_data <= w_assembled;
                            r_frame_strobe <= MAX_FRAMES'(1) << r_idx;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.frame_data = r_frame_data;
    assign bus.frame_strobe = r_frame_strobe;
    assign bus.busy = r_busy;
    assign bus.config_done = r_done;
    assign bus.error = r_error;
endmodule

// File: tb/tb_jtag_frame_loader.sv
// Bench for jtag_frame_loader: a 1-word and a 2-word frame instance
// share one stimulus stream and are checked against a protocol model.
module tb_jtag_frame_loader;
    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    jtag_frame_loader_if #(.FRAME_BITS(32), .MAX_FRAMES(20)) bus1 ();
    jtag_frame_loader_if #(.FRAME_BITS(64), .MAX_FRAMES(20)) bus2 ();

    jtag_frame_loader #(.FRAME_WORDS(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );
    jtag_frame_loader #(.FRAME_WORDS(2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    int n_checks = 0;
    int n_fail = 0;
    logic chk_on = 1'b0;

    // Protocol model: 0 = waiting for sync, 1 = expecting header, 2 = collecting data
    int          fw[2] = '{1, 2};
    int          m_mode[2];
    int          m_n[2];
    int          m_idx[2];
    logic [63:0] m_acc[2];
    logic [63:0] e_data[2];
    logic [19:0] e_strobe[2];
    logic        e_busy[2];
    logic        e_done[2];
    logic        e_err[2];

    int          s_cnt[2];
    logic [19:0] s_last[2];
    logic [63:0] s_data[2];
    logic [19:0] s_log[32];

    task automatic cmp(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0;
            m_n[i] = 0;
            m_idx[i] = 0;
            m_acc[i] = '0;
            e_data[i] = '0;
            e_strobe[i] = '0;
            e_busy[i] = 1'b0;
            e_done[i] = 1'b0;
            e_err[i] = 1'b0;
        end
    endfunction

    function automatic void model_word(int i, logic [31:0] w);
        case (m_mode[i])
            0: if (w == SYNC) begin
                m_mode[i] = 1;
                e_err[i] = 1'b0;
            end
            1: case (w[31:30])
                2'b00: if (int'(w[4:0]) < 20) begin
                    m_idx[i] = int'(w[4:0]);
                    m_acc[i] = '0;
                    m_n[i] = 0;
                    m_mode[i] = 2;
                end else begin
                    e_err[i] = 1'b1;
                    m_mode[i] = 0;
                end
                2'b01: begin
                    e_done[i] = 1'b1;
                    m_mode[i] = 0;
                end
                default: begin
                    e_err[i] = 1'b1;
                    m_mode[i] = 0;
                end
            endcase
            default: begin
                m_acc[i] = (m_acc[i] << 32) | {32'b0, w};
                m_n[i]++;
                if (m_n[i] == fw[i]) begin
                    e_data[i] = m_acc[i];
                    e_strobe[i] = 20'(1) << m_idx[i];
                    m_mode[i] = 1;
                end
            end
        endcase
        e_busy[i] = (m_mode[i] != 0);
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("d1.frame_data", {32'b0, bus1.frame_data}, e_data[0]);
            cmp("d1.frame_strobe", {44'b0, bus1.frame_strobe}, {44'b0, e_strobe[0]});
            cmp("d1.busy", {63'b0, bus1.busy}, {63'b0, e_busy[0]});
            cmp("d1.config_done", {63'b0, bus1.config_done}, {63'b0, e_done[0]});
            cmp("d1.error", {63'b0, bus1.error}, {63'b0, e_err[0]});
            cmp("d2.frame_data", bus2.frame_data, e_data[1]);
            cmp("d2.frame_strobe", {44'b0, bus2.frame_strobe}, {44'b0, e_strobe[1]});
            cmp("d2.busy", {63'b0, bus2.busy}, {63'b0, e_busy[1]});
            cmp("d2.config_done", {63'b0, bus2.config_done}, {63'b0, e_done[1]});
            cmp("d2.error", {63'b0, bus2.error}, {63'b0, e_err[1]});
            if (bus1.frame_strobe != '0) begin
                if (s_cnt[0] < 32) s_log[s_cnt[0]] = bus1.frame_strobe;
                s_cnt[0]++;
                s_last[0] = bus1.frame_strobe;
                s_data[0] = {32'b0, bus1.frame_data};
            end
            if (bus2.frame_strobe != '0) begin
                s_cnt[1]++;
                s_last[1] = bus2.frame_strobe;
                s_data[1] = bus2.frame_data;
            end
        end
    end

    // Starts and ends #1 after a rising edge. Strobe high `hold` clks, low 4.
    task automatic send_word(input logic [31:0] w, input int hold);
        bus1.config_data = w;
        bus2.config_data = w;
        bus1.config_strobe = 1'b1;
        bus2.config_strobe = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        model_word(0, w);
        model_word(1, w);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            e_strobe[i] = '0;
            e_done[i] = 1'b0;
        end
        repeat (hold - 4) @(posedge clk);
        if (hold > 4) #1;
        bus1.config_strobe = 1'b0;
        bus2.config_strobe = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        reset = 1'b0;
    endtask

    int c0;
    int c1;

    initial begin
        bus1.config_strobe = 1'b0;
        bus2.config_strobe = 1'b0;
        bus1.config_data = '0;
        bus2.config_data = '0;
        model_reset();
        s_cnt = '{0, 0};
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_on = 1'b1;

        repeat (20) @(posedge clk);
        #1;
        cmp("idle.busy", {63'b0, bus1.busy}, 64'd0);
        cmp("idle.frame_data", {32'b0, bus1.frame_data}, 64'd0);
        send_word(32'h1234_5678, 4);
        cmp("nosync.busy", {63'b0, bus1.busy}, 64'd0);
        cmp("nosync.strobes", 64'(s_cnt[0]), 64'd0);

        send_word(SYNC, 4);
        cmp("sync.busy", {63'b0, bus1.busy}, 64'd1);
        send_word(32'h0000_0003, 4);
        c0 = s_cnt[0];
        send_word(32'hDEAD_BEEF, 4);
        cmp("f3.count", 64'(s_cnt[0] - c0), 64'd1);
        cmp("f3.strobe", {44'b0, s_last[0]}, 64'h8);
        cmp("f3.data", s_data[0], 64'hDEAD_BEEF);
        cmp("f3.hold", {32'b0, bus1.frame_data}, 64'hDEAD_BEEF);
        send_word(32'h4000_0000, 4);
        cmp("end.busy", {63'b0, bus1.busy}, 64'd0);

        do_reset();
        send_word(SYNC, 4);
        send_word(32'h0000_0000, 4);
        c1 = s_cnt[1];
        send_word(32'hAAAA_0001, 4);
        cmp("fw2.nostrobe", 64'(s_cnt[1] - c1), 64'd0);
        send_word(32'hBBBB_0002, 4);
        cmp("fw2.count", 64'(s_cnt[1] - c1), 64'd1);
        cmp("fw2.data", s_data[1], 64'hAAAA_0001_BBBB_0002);
        cmp("fw2.strobe", {44'b0, s_last[1]}, 64'h1);

        do_reset();
        send_word(SYNC, 4);
        send_word(32'h0000_0014, 4);
        cmp("badidx.error", {63'b0, bus1.error}, 64'd1);
        cmp("badidx.busy", {63'b0, bus1.busy}, 64'd0);
        send_word(SYNC, 4);
        cmp("resync.error", {63'b0, bus1.error}, 64'd0);
        send_word(32'h8000_0000, 4);
        cmp("badop.error", {63'b0, bus1.error}, 64'd1);

        do_reset();
        send_word(SYNC, 4);
        send_word(32'h0000_0005, 4);
        do_reset();
        cmp("midrst.busy", {63'b0, bus1.busy}, 64'd0);
        c0 = s_cnt[0];
        send_word(32'h0000_0001, 4);
        cmp("midrst.nostrobe", 64'(s_cnt[0] - c0), 64'd0);
        cmp("midrst.data", {32'b0, bus1.frame_data}, 64'd0);

        send_word(SYNC, 50);
        cmp("hold.busy", {63'b0, bus1.busy}, 64'd1);
        send_word(32'h0000_0002, 4);
        c0 = s_cnt[0];
        send_word(32'h1111_2222, 4);
        cmp("hold.count", 64'(s_cnt[0] - c0), 64'd1);
        cmp("hold.strobe", {44'b0, s_last[0]}, 64'h4);
        cmp("hold.error", {63'b0, bus1.error}, 64'd0);

        do_reset();
        s_cnt[0] = 0;
        send_word(SYNC, 4);
        for (int k = 0; k < 20; k++) begin
            send_word(32'(k), 4);
            send_word(32'h5A00_0000 | 32'(k), 4);
        end
        cmp("b2b.count", 64'(s_cnt[0]), 64'd20);
        for (int k = 0; k < 20; k++) begin
            cmp("b2b.order", {44'b0, s_log[k]}, {44'b0, 20'(1) << k});
        end

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
